// File: rtl/id_queue_decoder_pkg.sv
// Shared widths, MIPS32 opcode/funct encodings and instruction-type enum
// for the queued decode stage.
package id_queue_decoder_pkg;

    localparam int unsigned WORD_WIDTH   = 32;
    localparam int unsigned OP_WIDTH     = 6;
    localparam int unsigned FUNCT_WIDTH  = 6;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned WORD_INDEX_W = 5;

    typedef enum logic [1:0] {
        R_TYPE = 2'd0,
        I_TYPE = 2'd1,
        J_TYPE = 2'd2
    } inst_type_t;

    localparam logic [OP_WIDTH-1:0] OP_SPECIAL   = 6'h00;
    localparam logic [OP_WIDTH-1:0] OP_BGEZ_BLTZ = 6'h01;
    localparam logic [OP_WIDTH-1:0] OP_J         = 6'h02;
    localparam logic [OP_WIDTH-1:0] OP_JAL       = 6'h03;
    localparam logic [OP_WIDTH-1:0] OP_BEQ       = 6'h04;
    localparam logic [OP_WIDTH-1:0] OP_BNE       = 6'h05;
    localparam logic [OP_WIDTH-1:0] OP_BLEZ      = 6'h06;
    localparam logic [OP_WIDTH-1:0] OP_BGTZ      = 6'h07;
    localparam logic [OP_WIDTH-1:0] OP_ADDI      = 6'h08;
    localparam logic [OP_WIDTH-1:0] OP_ADDIU     = 6'h09;
    localparam logic [OP_WIDTH-1:0] OP_SLTI      = 6'h0A;
    localparam logic [OP_WIDTH-1:0] OP_SLTIU     = 6'h0B;
    localparam logic [OP_WIDTH-1:0] OP_ANDI      = 6'h0C;
    localparam logic [OP_WIDTH-1:0] OP_ORI       = 6'h0D;
    localparam logic [OP_WIDTH-1:0] OP_XORI      = 6'h0E;
    localparam logic [OP_WIDTH-1:0] OP_LUI       = 6'h0F;
    localparam logic [OP_WIDTH-1:0] OP_LB        = 6'h20;
    localparam logic [OP_WIDTH-1:0] OP_LH        = 6'h21;
    localparam logic [OP_WIDTH-1:0] OP_LW        = 6'h23;
    localparam logic [OP_WIDTH-1:0] OP_LBU       = 6'h24;
    localparam logic [OP_WIDTH-1:0] OP_LHU       = 6'h25;
    localparam logic [OP_WIDTH-1:0] OP_SB        = 6'h28;
    localparam logic [OP_WIDTH-1:0] OP_SH        = 6'h29;
    localparam logic [OP_WIDTH-1:0] OP_SW        = 6'h2B;

    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLL = 6'h00;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRL = 6'h02;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRA = 6'h03;

endpackage

// File: rtl/id_queue_decoder_inst_fifo.sv
// Flushable FIFO of {pc, inst} pairs with a combinational head and entry count.
module inst_fifo #(
    parameter int unsigned W2    = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W2-1:0]            din,
    output logic [W2-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W2-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/id_queue_decoder.sv
// Decode stage: instruction queue feeding a registered MIPS32 field decoder,
// valid/ready on both sides, flushable, with optional empty-queue bypass.
module id_queue_decoder
    import id_queue_decoder_pkg::*;
#(
    parameter int unsigned W      = WORD_WIDTH,
    parameter int unsigned DEPTH  = 4,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W-1:0]              in_inst,
    input  logic [W-1:0]              in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                inst_type,
    output logic [OP_WIDTH-1:0]       op_code,
    output logic [FUNCT_WIDTH-1:0]    funct,
    output logic [REG_ADDR_W-1:0]     rs,
    output logic [REG_ADDR_W-1:0]     rt,
    output logic [REG_ADDR_W-1:0]     rd,
    output logic [WORD_INDEX_W-1:0]   shamt,
    output logic [W-1:0]              imm,
    output logic [W-1:0]              pc,
    output logic [$clog2(DEPTH):0]    occupancy
);

    logic [2*W-1:0] head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           can_load;
    logic           fire_in;
    logic           deq;
    logic           bypass;
    logic           load;
    logic [W-1:0]   src_inst;
    logic [W-1:0]   src_pc;
    logic [W-29:0]  pc4_hi;
    inst_type_t     dec_type;
    logic [W-1:0]   dec_imm;
    inst_type_t     type_q;

    assign in_ready = !fifo_full;
    assign can_load = !out_valid || out_ready;
    assign fire_in  = in_valid && in_ready;
    assign deq      = !fifo_empty && can_load;
    // Bypass only with an empty queue, so it can never overtake queued entries.
    assign bypass   = BYPASS && fifo_empty && can_load && fire_in;
    assign load     = deq || bypass;

    inst_fifo #(
        .W2    (2*W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (fire_in && !bypass),
        .pop   (deq),
        .din   ({in_pc, in_inst}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    assign {src_pc, src_inst} = deq ? head : {in_pc, in_inst};

    // Upper bits of pc+4: only a carry out of pc[27:2] can change them.
    assign pc4_hi = src_pc[W-1:28] + (W-28)'(&src_pc[27:2]);

    always_comb begin
        dec_type = I_TYPE;
        dec_imm  = '0;
        case (src_inst[31:26])
            OP_SPECIAL: begin
                dec_type = R_TYPE;
                if (src_inst[5:0] == FUNCT_SLL || src_inst[5:0] == FUNCT_SRL ||
                    src_inst[5:0] == FUNCT_SRA)
                    dec_imm = {{(W-5){1'b0}}, src_inst[10:6]};
            end
            OP_J, OP_JAL: begin
                dec_type = J_TYPE;
                dec_imm  = {pc4_hi, src_inst[25:0], 2'b00};
            end
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU:
                dec_imm = {{(W-16){src_inst[15]}}, src_inst[15:0]};
            OP_ANDI, OP_ORI, OP_XORI:
                dec_imm = {{(W-16){1'b0}}, src_inst[15:0]};
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BGEZ_BLTZ:
                dec_imm = {{(W-18){src_inst[15]}}, src_inst[15:0], 2'b00};
            OP_LUI:
                dec_imm = {src_inst[15:0], {(W-16){1'b0}}};
            default:
                dec_imm = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            type_q    <= I_TYPE;
            op_code   <= '0;
            funct     <= '0;
            rs        <= '0;
            rt        <= '0;
            rd        <= '0;
            shamt     <= '0;
            imm       <= '0;
            pc        <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            type_q    <= dec_type;
            op_code   <= src_inst[31:26];
            funct     <= src_inst[5:0];
            rs        <= src_inst[25:21];
            rt        <= src_inst[20:16];
            rd        <= src_inst[15:11];
            shamt     <= src_inst[10:6];
            imm       <= dec_imm;
            pc        <= src_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign inst_type = type_q;

endmodule

// File: tb/tb_id_queue_decoder.sv
// Drives a BYPASS=0 and a BYPASS=1 decoder with identical stimulus and checks
// both against a queue-based reference model plus directed expectations.
module tb_id_queue_decoder;
    import id_queue_decoder_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;

    logic        in_ready  [2];
    logic        out_valid [2];
    logic [1:0]  inst_type [2];
    logic [5:0]  op_code   [2];
    logic [5:0]  funct     [2];
    logic [4:0]  rs        [2];
    logic [4:0]  rt        [2];
    logic [4:0]  rd        [2];
    logic [4:0]  shamt     [2];
    logic [31:0] imm       [2];
    logic [31:0] pc        [2];
    logic [2:0]  occupancy [2];

    always #5 clk = ~clk;

    id_queue_decoder #(.W(32), .DEPTH(DEPTH), .BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid[0]), .out_ready(out_ready),
        .inst_type(inst_type[0]), .op_code(op_code[0]), .funct(funct[0]), .rs(rs[0]),
        .rt(rt[0]), .rd(rd[0]), .shamt(shamt[0]), .imm(imm[0]), .pc(pc[0]),
        .occupancy(occupancy[0]));

    id_queue_decoder #(.W(32), .DEPTH(DEPTH), .BYPASS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid[1]), .out_ready(out_ready),
        .inst_type(inst_type[1]), .op_code(op_code[1]), .funct(funct[1]), .rs(rs[1]),
        .rt(rt[1]), .rd(rd[1]), .shamt(shamt[1]), .imm(imm[1]), .pc(pc[1]),
        .occupancy(occupancy[1]));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: per-instance queue of {pc, inst} and the output slot.
    logic [63:0] mq   [2][$];
    bit          mov  [2];
    logic [63:0] mout [2];

    logic [5:0] op_tab [18] = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h07,
                                6'h08, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h20, 6'h23, 6'h25,
                                6'h2B, 6'h3F};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Decoding rules stated directly in arithmetic: returns {type, imm}.
    function automatic logic [33:0] ref_dec(input logic [31:0] inst, input logic [31:0] ipc);
        logic [5:0]  op;
        logic [31:0] sx;
        op = inst[31:26];
        sx = {{16{inst[15]}}, inst[15:0]};
        if (op == 6'h00)
            return {R_TYPE, (inst[5:0] inside {6'd0, 6'd2, 6'd3}) ? {27'd0, inst[10:6]} : 32'd0};
        if (op inside {6'h02, 6'h03})
            return {J_TYPE, ((ipc + 32'd4) & 32'hF000_0000) | (32'(inst[25:0]) * 32'd4)};
        if (op inside {6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h28, 6'h29, 6'h2B,
                       6'h08, 6'h09, 6'h0A, 6'h0B})
            return {I_TYPE, sx};
        if (op inside {6'h0C, 6'h0D, 6'h0E}) return {I_TYPE, 32'(inst[15:0])};
        if (op inside {6'h04, 6'h05, 6'h06, 6'h07, 6'h01}) return {I_TYPE, sx * 32'd4};
        if (op == 6'h0F) return {I_TYPE, 32'(inst[15:0]) * 32'h10000};
        return {I_TYPE, 32'd0};
    endfunction

    task automatic model_step(input int k, input bit v, input logic [63:0] item,
                              input bit ordy, input bit fl);
        bit can_load, fire;
        can_load = !mov[k] || ordy;
        fire     = v && (mq[k].size() < DEPTH);
        if (fl) begin
            mq[k].delete();
            mov[k] = 0;
        end else if (mq[k].size() != 0 && can_load) begin
            mout[k] = mq[k].pop_front();
            mov[k]  = 1;
            if (fire) mq[k].push_back(item);
        end else if (fire && k == 1 && can_load) begin
            mout[k] = item;
            mov[k]  = 1;
        end else begin
            if (fire) mq[k].push_back(item);
            if (mov[k] && ordy) mov[k] = 0;
        end
    endtask

    task automatic check_all();
        logic [33:0] d;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("b%0d.occupancy", k), 64'(occupancy[k]), 64'(mq[k].size()));
            chk($sformatf("b%0d.in_ready", k), 64'(in_ready[k]), 64'(mq[k].size() < DEPTH));
            chk($sformatf("b%0d.out_valid", k), 64'(out_valid[k]), 64'(mov[k]));
            if (mov[k]) begin
                d = ref_dec(mout[k][31:0], mout[k][63:32]);
                chk($sformatf("b%0d.inst_type", k), 64'(inst_type[k]), 64'(d[33:32]));
                chk($sformatf("b%0d.imm", k), 64'(imm[k]), 64'(d[31:0]));
                chk($sformatf("b%0d.pc", k), 64'(pc[k]), 64'(mout[k][63:32]));
                chk($sformatf("b%0d.fields", k),
                    {38'd0, op_code[k], rs[k], rt[k], rd[k], shamt[k], funct[k]},
                    {32'd0, mout[k][31:0]});
            end
        end
    endtask

    // Inputs are applied after a falling edge; outputs are checked 1 ns after the rising edge.
    task automatic cycle(input bit v, input logic [31:0] inst, input logic [31:0] ipc,
                         input bit ordy, input bit fl);
        in_valid = v; in_inst = inst; in_pc = ipc; out_ready = ordy; flush = fl;
        for (int k = 0; k < 2; k++) model_step(k, v, {ipc, inst}, ordy, fl);
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s.b%0d.out_valid", tag, k), 64'(out_valid[k]), 64'd0);
            chk($sformatf("%s.b%0d.occupancy", tag, k), 64'(occupancy[k]), 64'd0);
            chk($sformatf("%s.b%0d.in_ready", tag, k), 64'(in_ready[k]), 64'd1);
            chk($sformatf("%s.b%0d.inst_type", tag, k), 64'(inst_type[k]), 64'(I_TYPE));
            chk($sformatf("%s.b%0d.fields", tag, k),
                {op_code[k], funct[k], rs[k], rt[k], rd[k], shamt[k], imm[k], pc[k]}, 64'd0);
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] x;
        x = $urandom;
        if ($urandom_range(0, 7) != 0) x[31:26] = op_tab[$urandom_range(0, 17)];
        if (x[31:26] == 6'h00 && $urandom_range(0, 1) == 1)
            x[5:0] = 6'($urandom_range(0, 1) == 1 ? 2 + $urandom_range(0, 1) : 0);
        return x;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        for (int k = 0; k < 2; k++) begin mov[k] = 0; mout[k] = '0; end
        #2;
        check_cleared("reset");
        @(negedge clk);
        rst = 1'b0;

        // ADDI $8,$0,-1: bypass instance shows it after the first edge
        cycle(1, 32'h2008FFFF, 32'h0000_0100, 1, 0);
        chk("t1.b1.out_valid", 64'(out_valid[1]), 64'd1);
        chk("t1.b1.rt_rs", {54'd0, rt[1], rs[1]}, {54'd0, 5'd8, 5'd0});
        chk("t1.b1.imm", 64'(imm[1]), 64'hFFFF_FFFF);
        chk("t1.b1.inst_type", 64'(inst_type[1]), 64'(I_TYPE));
        chk("t1.b0.out_valid", 64'(out_valid[0]), 64'd0);
        cycle(0, 32'h0, 32'h0, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // LUI then SLL back to back
        cycle(1, 32'h3C011234, 32'h0000_0200, 1, 0);
        chk("t2.b1.imm", 64'(imm[1]), 64'h1234_0000);
        cycle(1, 32'h00031140, 32'h0000_0204, 1, 0);
        chk("t2.b0.imm", 64'(imm[0]), 64'h1234_0000);
        cycle(0, 32'h0, 32'h0, 1, 0);
        chk("t2.b0.sll", {49'd0, rd[0], rt[0], shamt[0]}, {49'd0, 5'd2, 5'd3, 5'd5});
        chk("t2.b0.imm2", 64'(imm[0]), 64'd5);
        chk("t2.b0.type2", 64'(inst_type[0]), 64'(R_TYPE));
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Fill with out_ready low, hold, then drain in order
        for (int i = 0; i <= DEPTH; i++)
            cycle(1, rand_inst(), 32'h0000_1000 + 32'(i) * 4, 0, 0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("t3.b%0d.occupancy", k), 64'(occupancy[k]), 64'(DEPTH));
            chk($sformatf("t3.b%0d.in_ready", k), 64'(in_ready[k]), 64'd0);
        end
        for (int i = 0; i < 3; i++) cycle(1, 32'h2000_0001, 32'h0000_1FFC, 0, 0);
        for (int i = 0; i < DEPTH + 3; i++) cycle(0, 32'h0, 32'h0, 1, 0);
        chk("t3.b0.drained", 64'(out_valid[0]), 64'd0);

        // J absolute target, BEQ backward offset
        cycle(1, 32'h08000004, 32'h4000_0000, 1, 0);
        chk("t4.b1.j_imm", 64'(imm[1]), 64'h4000_0010);
        chk("t4.b1.j_type", 64'(inst_type[1]), 64'(J_TYPE));
        cycle(1, 32'h1000FFFF, 32'h4000_0004, 1, 0);
        chk("t4.b0.j_imm", 64'(imm[0]), 64'h4000_0010);
        chk("t4.b1.beq_imm", 64'(imm[1]), 64'hFFFF_FFFC);
        cycle(0, 32'h0, 32'h0, 1, 0);
        chk("t4.b0.beq_imm", 64'(imm[0]), 64'hFFFF_FFFC);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Flush with three queued entries and a same-cycle input
        for (int i = 0; i < 4; i++) cycle(1, rand_inst(), 32'h0000_2000 + 32'(i) * 4, 0, 0);
        for (int k = 0; k < 2; k++)
            chk($sformatf("t5.b%0d.pre", k), {62'd0, out_valid[k], 1'b0} | 64'(occupancy[k]), 64'd3 | 64'd2);
        cycle(1, 32'h2409_0077, 32'h0000_3000, 0, 1);
        for (int k = 0; k < 2; k++)
            chk($sformatf("t5.b%0d.post", k), {61'd0, in_ready[k], out_valid[k], 1'b0} | 64'(occupancy[k]), 64'd4);
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 32'h0, 1, 0);
        chk("t5.b0.quiet", 64'(out_valid[0]), 64'd0);

        // Asynchronous reset between edges, then ORI
        cycle(1, rand_inst(), 32'h0000_4000, 0, 0);
        cycle(1, rand_inst(), 32'h0000_4004, 0, 0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_cleared("t6.async");
        for (int k = 0; k < 2; k++) begin mq[k].delete(); mov[k] = 0; end
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 32'h3402FFFF, 32'h0000_5000, 1, 0);
        chk("t6.b1.ori", 64'(imm[1]), 64'h0000_FFFF);
        cycle(0, 32'h0, 32'h0, 1, 0);
        chk("t6.b0.ori", 64'(imm[0]), 64'h0000_FFFF);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++)
            cycle($urandom_range(0, 9) < 7, rand_inst(), $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
